// File: rtl/delta_calc.sv
// Backprop error terms (output and hidden deltas) on one time-shared Q-format multiplier.
// Define DELTA_CALC_SAT_EN to saturate products and sums; otherwise results wrap.
module delta_calc #(
   parameter int N_IN   = 2,
   parameter int N_HL_P = 3,
   parameter int N_OUT  = 2,
   parameter int WIDTH  = 32,
   parameter int FRAC   = 24
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [N_OUT*WIDTH-1:0]          i_t,
   input  logic [N_OUT*WIDTH-1:0]          i_o_a,
   input  logic [N_HL_P*WIDTH-1:0]         i_hd_a,
   input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_wght_o,
   output logic [N_OUT*WIDTH-1:0]          o_dlto,
   output logic [N_HL_P*WIDTH-1:0]         o_dlth,
   output logic                            o_busy,
   output logic                            o_valid
);

   localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int JW = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;

   localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic signed [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_OUT_DER = 3'd1;
   localparam logic [2:0] S_OUT_MUL = 3'd2;
   localparam logic [2:0] S_HID_ACC = 3'd3;
   localparam logic [2:0] S_HID_DER = 3'd4;
   localparam logic [2:0] S_HID_MUL = 3'd5;

   function automatic logic signed [WIDTH-1:0] add_q(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y);
`ifdef DELTA_CALC_SAT_EN
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
      if (s[WIDTH] != s[WIDTH-1]) add_q = s[WIDTH] ? VMIN : VMAX;
      else                        add_q = s[WIDTH-1:0];
`else
      add_q = x + y;
`endif
   endfunction

   function automatic logic signed [WIDTH-1:0] sub_q(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y);
`ifdef DELTA_CALC_SAT_EN
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x} - {y[WIDTH-1], y};
      if (s[WIDTH] != s[WIDTH-1]) sub_q = s[WIDTH] ? VMIN : VMAX;
      else                        sub_q = s[WIDTH-1:0];
`else
      sub_q = x - y;
`endif
   endfunction

   // Full 2*WIDTH product, arithmetic shift by FRAC, reduced to WIDTH bits.
   function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y);
      logic signed [2*WIDTH-1:0] xe;
      logic signed [2*WIDTH-1:0] ye;
      xe = {{WIDTH{x[WIDTH-1]}}, x};
      ye = {{WIDTH{y[WIDTH-1]}}, y};
`ifdef DELTA_CALC_SAT_EN
      begin
         logic signed [2*WIDTH-1:0] p;
         p = (xe * ye) >>> FRAC;
         if (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[2*WIDTH-1]}})
            mul_q = p[2*WIDTH-1] ? VMIN : VMAX;
         else
            mul_q = p[WIDTH-1:0];
      end
`else
      mul_q = WIDTH'((xe * ye) >>> FRAC);
`endif
   endfunction

   logic [2:0]              state;
   logic [KW-1:0]           k;
   logic [JW-1:0]           j;
   logic signed [WIDTH-1:0] t_q   [N_OUT];
   logic signed [WIDTH-1:0] a_q   [N_OUT];
   logic signed [WIDTH-1:0] h_q   [N_HL_P];
   logic signed [WIDTH-1:0] w_q   [N_OUT][N_HL_P];
   logic signed [WIDTH-1:0] dlto  [N_OUT];
   logic signed [WIDTH-1:0] dlth  [N_HL_P];
   logic signed [WIDTH-1:0] d;
   logic signed [WIDTH-1:0] acc;
   logic signed [WIDTH-1:0] ma;
   logic signed [WIDTH-1:0] mb;
   logic signed [WIDTH-1:0] prod;

   // Operand select for the shared multiplier
   always_comb begin
      ma = '0;
      mb = '0;
      case (state)
         S_OUT_DER: begin ma = a_q[k];    mb = sub_q(ONE, a_q[k]);      end
         S_OUT_MUL: begin ma = sub_q(a_q[k], t_q[k]); mb = d;           end
         S_HID_ACC: begin ma = w_q[k][j]; mb = dlto[k];                 end
         S_HID_DER: begin ma = h_q[j];    mb = sub_q(ONE, h_q[j]);      end
         S_HID_MUL: begin ma = acc;       mb = d;                       end
         default:   begin ma = '0;        mb = '0;                      end
      endcase
      prod = mul_q(ma, mb);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         k       <= '0;
         j       <= '0;
         d       <= '0;
         acc     <= '0;
         o_busy  <= 1'b0;
         o_valid <= 1'b0;
         for (int m = 0; m < N_OUT; m++) begin
            t_q[m]  <= '0;
            a_q[m]  <= '0;
            dlto[m] <= '0;
            for (int n = 0; n < N_HL_P; n++) w_q[m][n] <= '0;
         end
         for (int n = 0; n < N_HL_P; n++) begin
            h_q[n]  <= '0;
            dlth[n] <= '0;
         end
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en) begin
                  for (int m = 0; m < N_OUT; m++) begin
                     t_q[m] <= i_t[m*WIDTH +: WIDTH];
                     a_q[m] <= i_o_a[m*WIDTH +: WIDTH];
                     for (int n = 0; n < N_HL_P; n++)
                        w_q[m][n] <= i_wght_o[(m*N_HL_P+n)*WIDTH +: WIDTH];
                  end
                  for (int n = 0; n < N_HL_P; n++) h_q[n] <= i_hd_a[n*WIDTH +: WIDTH];
                  k      <= '0;
                  o_busy <= 1'b1;
                  state  <= S_OUT_DER;
               end
            end
            S_OUT_DER: begin
               d     <= prod;
               state <= S_OUT_MUL;
            end
            S_OUT_MUL: begin
               dlto[k] <= prod;
               if (k == KW'(N_OUT-1)) begin
                  k     <= '0;
                  j     <= '0;
                  acc   <= '0;
                  state <= S_HID_ACC;
               end else begin
                  k     <= k + KW'(1);
                  state <= S_OUT_DER;
               end
            end
            S_HID_ACC: begin
               acc <= add_q(acc, prod);
               if (k == KW'(N_OUT-1)) begin
                  k     <= '0;
                  state <= S_HID_DER;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_HID_DER: begin
               d     <= prod;
               state <= S_HID_MUL;
            end
            S_HID_MUL: begin
               dlth[j] <= prod;
               if (j == JW'(N_HL_P-1)) begin
                  o_valid <= 1'b1;
                  o_busy  <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  j     <= j + JW'(1);
                  k     <= '0;
                  acc   <= '0;
                  state <= S_HID_ACC;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_dlto
      assign o_dlto[g*WIDTH +: WIDTH] = dlto[g];
   end
   for (genvar g = 0; g < N_HL_P; g++) begin : g_dlth
      assign o_dlth[g*WIDTH +: WIDTH] = dlth[g];
   end

endmodule

// File: tb/tb_delta_calc.sv
// Directed bench for delta_calc at default parameters (Q8.24, 2 outputs, 3 hidden).
module tb_delta_calc;
   localparam logic [31:0] ONE  = 32'h0100_0000;
   localparam logic [31:0] HALF = 32'h0080_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [63:0]  i_t;
   logic [63:0]  i_o_a;
   logic [95:0]  i_hd_a;
   logic [191:0] i_wght_o;
   logic [63:0]  o_dlto;
   logic [95:0]  o_dlth;
   logic         o_busy;
   logic         o_valid;

   logic [31:0] t  [2];
   logic [31:0] oa [2];
   logic [31:0] hd [3];
   logic [31:0] w  [2][3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   delta_calc dut (
      .clk(clk), .rst(rst), .en(en),
      .i_t(i_t), .i_o_a(i_o_a), .i_hd_a(i_hd_a), .i_wght_o(i_wght_o),
      .o_dlto(o_dlto), .o_dlth(o_dlth), .o_busy(o_busy), .o_valid(o_valid)
   );

   always_comb begin
      i_t = '0; i_o_a = '0; i_hd_a = '0; i_wght_o = '0;
      for (int m = 0; m < 2; m++) begin
         i_t[m*32 +: 32]   = t[m];
         i_o_a[m*32 +: 32] = oa[m];
         for (int n = 0; n < 3; n++) i_wght_o[(m*3+n)*32 +: 32] = w[m][n];
      end
      for (int n = 0; n < 3; n++) i_hd_a[n*32 +: 32] = hd[n];
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_basic(input logic [31:0] w1);
      oa[0] = HALF; oa[1] = HALF;
      t[0] = 32'h0;  t[1] = ONE;
      for (int n = 0; n < 3; n++) begin
         hd[n] = HALF; w[0][n] = ONE; w[1][n] = w1;
      end
   endtask

   task automatic start();
      en = 1'b1;
      tick();
      en = 1'b0;
   endtask

   // Ticks until o_valid, returning the number of edges taken (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (!o_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic count_valid(input int cycles, output int nv);
      nv = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (o_valid) nv++;
      end
   endtask

   // Reference arithmetic on 64-bit integers.
   function automatic logic [31:0] clamp(input longint v);
`ifdef DELTA_CALC_SAT_EN
      if (v > 64'sh7FFF_FFFF)       return 32'h7FFF_FFFF;
      if (v < -64'sh8000_0000)      return 32'h8000_0000;
`endif
      return v[31:0];
   endfunction
   function automatic logic [31:0] r_mul(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return clamp(p >>> 24);
   endfunction
   function automatic logic [31:0] r_add(input logic [31:0] x, input logic [31:0] y);
      return clamp(longint'($signed(x)) + longint'($signed(y)));
   endfunction
   function automatic logic [31:0] r_sub(input logic [31:0] x, input logic [31:0] y);
      return clamp(longint'($signed(x)) - longint'($signed(y)));
   endfunction

   logic [31:0] e_o [2];
   logic [31:0] e_h [3];
   task automatic ref_model();
      logic [31:0] acc;
      for (int m = 0; m < 2; m++)
         e_o[m] = r_mul(r_sub(oa[m], t[m]), r_mul(oa[m], r_sub(ONE, oa[m])));
      for (int n = 0; n < 3; n++) begin
         acc = '0;
         for (int m = 0; m < 2; m++) acc = r_add(acc, r_mul(w[m][n], e_o[m]));
         e_h[n] = r_mul(acc, r_mul(hd[n], r_sub(ONE, hd[n])));
      end
   endtask

   localparam logic [63:0] BASIC_DLTO = {32'hFFE0_0000, 32'h0020_0000};
   localparam logic [95:0] BASIC_DLTH = {3{32'h0008_0000}};

   initial begin
      int n, nv, busy_bad, busy_after;
      logic [63:0] first_o;
      logic [95:0] first_h;
      rst = 1'b1; en = 1'b0;
      for (int m = 0; m < 2; m++) begin
         t[m] = '0; oa[m] = '0;
         for (int q = 0; q < 3; q++) w[m][q] = '0;
      end
      for (int q = 0; q < 3; q++) hd[q] = '0;
      repeat (3) tick();
      check("rst_dlto",  o_dlto,  0);
      check("rst_dlth",  o_dlth,  0);
      check("rst_busy",  o_busy,  0);
      check("rst_valid", o_valid, 0);
      rst = 1'b0;
      tick();

      // Basic
      load_basic(32'h0);
      start();
      check("basic_busy_e0", o_busy, 1);
      wait_valid(n);
      check("basic_latency", n, 16);
      check("basic_dlto", o_dlto, BASIC_DLTO);
      check("basic_dlth", o_dlth, BASIC_DLTH);
      check("basic_busy_end", o_busy, 0);
      tick();
      check("basic_valid_drop", o_valid, 0);

      // Cancel-out
      load_basic(ONE);
      start();
      wait_valid(n);
      check("cancel_latency", n, 16);
      check("cancel_dlto", o_dlto, BASIC_DLTO);
      check("cancel_dlth", o_dlth, 0);
      tick();

      // Busy handling: stray starts and input changes mid-run
      load_basic(32'h0);
      start();
      busy_bad = 0;
      for (int c = 0; c < 16; c++) begin
         if (!o_busy || o_valid) busy_bad++;
         en = (c == 3 || c == 10);
         if (c == 5) begin
            for (int m = 0; m < 2; m++) begin
               t[m] = 32'h1234_5678; oa[m] = 32'h0030_0000;
               for (int q = 0; q < 3; q++) w[m][q] = 32'hFF00_0000;
            end
            for (int q = 0; q < 3; q++) hd[q] = 32'h0020_0000;
         end
         tick();
      end
      en = 1'b0;
      check("busy_window", busy_bad, 0);
      check("busy_valid", o_valid, 1);
      check("busy_clear", o_busy, 0);
      check("busy_dlto", o_dlto, BASIC_DLTO);
      check("busy_dlth", o_dlth, BASIC_DLTH);
      busy_after = 0;
      nv = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (o_valid) nv++;
         if (o_busy) busy_after++;
      end
      check("busy_single_valid", nv, 0);
      check("busy_no_restart", busy_after, 0);

      // Reset mid-operation
      load_basic(32'h0);
      start();
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_dlto",  o_dlto,  0);
      check("midrst_dlth",  o_dlth,  0);
      check("midrst_busy",  o_busy,  0);
      check("midrst_valid", o_valid, 0);
      count_valid(20, nv);
      check("midrst_no_valid", nv, 0);
      start();
      wait_valid(n);
      check("midrst_restart_latency", n, 16);
      check("midrst_restart_dlto", o_dlto, BASIC_DLTO);
      check("midrst_restart_dlth", o_dlth, BASIC_DLTH);
      tick();

      // Back-to-back with en held high
      en = 1'b1;
      tick();
      wait_valid(n);
      check("b2b_first_latency", n, 16);
      first_o = o_dlto;
      first_h = o_dlth;
      tick();
      n = 1;
      while (!o_valid && n < 40) begin
         tick();
         n++;
      end
      en = 1'b0;
      check("b2b_interval", n, 17);
      check("b2b_dlto", o_dlto, first_o);
      check("b2b_dlth", o_dlth, first_h);
      check("b2b_dlto_val", o_dlto, BASIC_DLTO);
      count_valid(20, nv);
      check("b2b_stop", nv, 0);

      // Overflow
      load_basic(32'h0);
      oa[0] = 32'h7FFF_FFFF;
      t[0]  = 32'h0;
      ref_model();
      start();
      wait_valid(n);
      check("ovf_latency", n, 16);
      check("ovf_dlto0", o_dlto[31:0],  e_o[0]);
      check("ovf_dlto1", o_dlto[63:32], e_o[1]);
      check("ovf_dlth", o_dlth, {e_h[2], e_h[1], e_h[0]});
`ifdef DELTA_CALC_SAT_EN
      check("ovf_sat_dlto0", o_dlto[31:0], 32'h8000_0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
